// File: rtl/phase_seq.sv
// Fine-grain phase sequencer: splits each instruction period into NUM_STAGES
// windows sized by per-stage delay codes, with fixed-period, clamp and stall hold.
module phase_seq #(
  parameter int NUM_STAGES   = 5,
  parameter int DLY_W        = 4,
  parameter int MIN_PERIOD   = 4,
  parameter int MEM_STAGE    = 3,
  localparam int CNT_W       = $clog2(NUM_STAGES * 2**DLY_W + MIN_PERIOD + 1),
  localparam int IDX_W       = $clog2(NUM_STAGES)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        iEn,
  input  logic                        iStall,
  input  logic [NUM_STAGES*DLY_W-1:0] iStageDly,
  input  logic                        iFixedMode,
  input  logic [CNT_W-1:0]            iFixedPeriod,
  output logic                        oFePulse,
  output logic                        oMemPulse,
  output logic [NUM_STAGES-1:0]       oStageDone,
  output logic [IDX_W-1:0]            oStageIdx,
  output logic                        oBusy,
  output logic [CNT_W-1:0]            oPeriodLen
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_RUN   = 2'd1;
  localparam logic [1:0]       S_HOLD  = 2'd2;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_PERIOD);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] next_len;
  logic [CNT_W-1:0] stage_sum;
  logic [DLY_W-1:0] dly_q [NUM_STAGES];
  logic [IDX_W-1:0] stage_idx;
  logic [DLY_W-1:0] stage_cnt;
  logic             run_end;
  logic             period_done;
  logic             load;
  logic             stage_last;

  // Candidate length for the next period, taken straight from the live inputs.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // variable a default first, so no latch is inferred on any path.
    stage_sum = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      stage_sum = stage_sum + CNT_W'(iStageDly[i*DLY_W +: DLY_W]) + CNT_W'(1);
    next_len = iFixedMode ? iFixedPeriod : stage_sum;
    if (next_len < MIN_LEN)
      next_len = MIN_LEN;
  end

  assign run_end     = (state == S_RUN) && (cnt == len - CNT_W'(1));
  assign period_done = (run_end || state == S_HOLD) && !iStall;
  assign load        = (state == S_IDLE && iEn) || (period_done && iEn);

  // A clamp-padded or truncated period always closes its current stage at L-1.
  assign stage_last = (state == S_RUN) &&
                      (run_end || (stage_idx != LAST && stage_cnt == dly_q[stage_idx]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      len       <= '0;
      stage_idx <= '0;
      stage_cnt <= '0;
      // NOTE: the delay store is a handful of flops, not a RAM, and its value
      // is visible through stage timing, so it is reset along with the rest.
      for (int i = 0; i < NUM_STAGES; i++)
        dly_q[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every register samples
      // the pre-edge values regardless of statement order.
      if (load) begin
        len <= next_len;
        for (int i = 0; i < NUM_STAGES; i++)
          dly_q[i] <= iStageDly[i*DLY_W +: DLY_W];
      end

      if (period_done) begin
        state     <= iEn ? S_RUN : S_IDLE;
        cnt       <= '0;
        stage_idx <= '0;
        stage_cnt <= '0;
      end else if (state == S_IDLE) begin
        if (iEn)
          state <= S_RUN;
      end else if (run_end) begin
        state <= S_HOLD;
      end else if (state == S_RUN) begin
        cnt <= cnt + CNT_W'(1);
        if (stage_idx != LAST) begin
          if (stage_cnt == dly_q[stage_idx]) begin
            stage_idx <= stage_idx + IDX_W'(1);
            stage_cnt <= '0;
          end else begin
            stage_cnt <= stage_cnt + DLY_W'(1);
          end
        end
      end
    end
  end

  assign oFePulse   = period_done;
  assign oStageDone = stage_last ? (NUM_STAGES'(1) << stage_idx) : '0;
  assign oMemPulse  = oStageDone[MEM_STAGE];
  assign oStageIdx  = stage_idx;
  assign oBusy      = (state != S_IDLE);
  assign oPeriodLen = len;

endmodule

// File: tb/tb_phase_seq.sv
// Bench for phase_seq: two instances (MIN_PERIOD 4 and 8) checked every cycle
// against a period/position reference model, plus directed timing checks.
module tb_phase_seq;

  localparam int NS  = 5;
  localparam int DW  = 4;
  localparam int MEM = 3;
  localparam int CW  = $clog2(NS * 2**DW + 8 + 1);
  localparam int IW  = $clog2(NS);

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic             stall;
  logic [NS*DW-1:0] stage_dly;
  logic             fixed_mode;
  logic [CW-1:0]    fixed_period;

  logic          fe5, mem5, busy5, fe8, mem8, busy8;
  logic [NS-1:0] done5, done8;
  logic [IW-1:0] idx5, idx8;
  logic [CW-1:0] plen5, plen8;

  int vectors;
  int miscompares;
  int fe_cnt;
  int mem_cnt;
  bit last_fe;

  always #5 clk = ~clk;

  phase_seq #(.NUM_STAGES(NS), .DLY_W(DW), .MIN_PERIOD(4), .MEM_STAGE(MEM)) u5 (
    .clk(clk), .rstn(rstn), .iEn(en), .iStall(stall), .iStageDly(stage_dly),
    .iFixedMode(fixed_mode), .iFixedPeriod(fixed_period),
    .oFePulse(fe5), .oMemPulse(mem5), .oStageDone(done5), .oStageIdx(idx5),
    .oBusy(busy5), .oPeriodLen(plen5));

  phase_seq #(.NUM_STAGES(NS), .DLY_W(DW), .MIN_PERIOD(8), .MEM_STAGE(MEM)) u8 (
    .clk(clk), .rstn(rstn), .iEn(en), .iStall(stall), .iStageDly(stage_dly),
    .iFixedMode(fixed_mode), .iFixedPeriod(fixed_period),
    .oFePulse(fe8), .oMemPulse(mem8), .oStageDone(done8), .oStageIdx(idx8),
    .oBusy(busy8), .oPeriodLen(plen8));

  typedef enum int {M_IDLE, M_RUN, M_HOLD} mmode_e;
  typedef struct {
    mmode_e           mode;
    int               pos;
    int               len;
    logic [NS*DW-1:0] dly;
  } model_t;
  typedef struct {
    int fe;
    int mem;
    int done;
    int idx;
    int busy;
    int plen;
  } exp_t;

  model_t m5, m8;

  function automatic model_t idle_model();
    model_t m;
    m.mode = M_IDLE;
    m.pos  = 0;
    m.len  = 0;
    m.dly  = '0;
    return m;
  endfunction

  function automatic int dly_of(logic [NS*DW-1:0] v, int i);
    return int'(v[i*DW +: DW]);
  endfunction

  function automatic logic [NS*DW-1:0] pack(int d0, int d1, int d2, int d3, int d4);
    return {DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // Stage k covers cycles [sum_{j<k}(d_j+1), sum_{j<=k}(d_j+1)); the last stage takes the rest.
  function automatic int stage_at(model_t m, int pos);
    int acc = 0;
    for (int i = 0; i < NS - 1; i++) begin
      acc += dly_of(m.dly, i) + 1;
      if (pos < acc) return i;
    end
    return NS - 1;
  endfunction

  function automatic int period_len(int minp);
    int l = 0;
    if (fixed_mode) l = int'(fixed_period);
    else for (int i = 0; i < NS; i++) l += dly_of(stage_dly, i) + 1;
    return (l < minp) ? minp : l;
  endfunction

  function automatic exp_t expect_out(model_t m);
    exp_t e;
    bit   at_end;
    e = '{default: 0};
    at_end = (m.mode == M_RUN && m.pos == m.len - 1) || m.mode == M_HOLD;
    e.fe   = int'(at_end && !stall);
    e.busy = int'(m.mode != M_IDLE);
    e.plen = m.len;
    if (m.mode == M_RUN)  e.idx = stage_at(m, m.pos);
    if (m.mode == M_HOLD) e.idx = stage_at(m, m.len - 1);
    if (m.mode == M_RUN && (m.pos == m.len - 1 || stage_at(m, m.pos + 1) != e.idx))
      e.done = 1 << e.idx;
    e.mem = (e.done >> MEM) & 1;
    return e;
  endfunction

  function automatic model_t start_period(model_t m, int minp);
    model_t n = m;
    n.pos = 0;
    if (en) begin
      n.mode = M_RUN;
      n.len  = period_len(minp);
      n.dly  = stage_dly;
    end else begin
      n.mode = M_IDLE;
    end
    return n;
  endfunction

  function automatic model_t model_next(model_t m, int minp);
    model_t n = m;
    case (m.mode)
      M_IDLE: if (en) n = start_period(m, minp);
      M_RUN: begin
        if (m.pos == m.len - 1) n = stall ? '{M_HOLD, m.pos, m.len, m.dly} : start_period(m, minp);
        else n.pos = m.pos + 1;
      end
      default: if (!stall) n = start_period(m, minp);
    endcase
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(string who, exp_t e, logic fe, logic mem, logic [NS-1:0] done,
                           logic [IW-1:0] idx, logic busy, logic [CW-1:0] plen);
    check({who, "_fe"},   32'(fe),   e.fe);
    check({who, "_mem"},  32'(mem),  e.mem);
    check({who, "_done"}, 32'(done), e.done);
    check({who, "_idx"},  32'(idx),  e.idx);
    check({who, "_busy"}, 32'(busy), e.busy);
    check({who, "_plen"}, 32'(plen), e.plen);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    check_dut("u5", expect_out(m5), fe5, mem5, done5, idx5, busy5, plen5);
    check_dut("u8", expect_out(m8), fe8, mem8, done8, idx8, busy8, plen8);
    last_fe = fe5;
    fe_cnt  += int'(fe5);
    mem_cnt += int'(mem5);
    @(posedge clk);
    m5 = model_next(m5, 4);
    m8 = model_next(m8, 8);
    @(negedge clk);
  endtask

  task automatic run_to_fe(input int budget, output int waited);
    bit got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      cycle();
      waited++;
      got = last_fe;
    end
    check("fe_wait", 32'(got), 1);
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; fe_cnt = 0; mem_cnt = 0; last_fe = 1'b0;
    rstn = 1'b0; en = 1'b0; stall = 1'b0; stage_dly = '0;
    fixed_mode = 1'b0; fixed_period = '0;
    m5 = idle_model();
    m8 = idle_model();
    #1;
    check_dut("por5", expect_out(m5), fe5, mem5, done5, idx5, busy5, plen5);
    check_dut("por8", expect_out(m8), fe8, mem8, done8, idx8, busy8, plen8);
    @(negedge clk);
    rstn = 1'b1;

    // Default stage walk: L=5 on u5, clamped L=8 on u8.
    en = 1'b1;
    repeat (16) cycle();
    check("t1_len5", 32'(plen5), 5);
    check("t3_len8", 32'(plen8), 8);

    // Uneven delays, then a mid-period change that must wait for the boundary.
    stage_dly = pack(1, 0, 2, 0, 0);
    run_to_fe(20, n);
    check("t2_len", 32'(plen5), 8);
    repeat (3) cycle();
    stage_dly = pack(3, 3, 3, 3, 3);
    run_to_fe(20, n);
    check("t2_keep", 32'(n), 5);
    check("t2_newlen", 32'(plen5), 20);

    // Back to zero delays: u8 shows the clamp padding into the last stage.
    stage_dly = '0;
    run_to_fe(30, n);
    repeat (16) cycle();

    // Stall arriving exactly at u5's period end, held three cycles.
    n = 0;
    while (!(m5.mode == M_RUN && m5.pos == m5.len - 1) && n < 20) begin
      cycle();
      n++;
    end
    check("t4_align", 32'(m5.pos), 32'(m5.len - 1));
    fe_cnt = 0; mem_cnt = 0;
    stall = 1'b1;
    repeat (3) cycle();
    check("t4_nofe", 32'(fe_cnt), 0);
    stall = 1'b0;
    cycle();
    check("t4_fe", 32'(last_fe), 1);
    check("t4_mem", 32'(mem_cnt), 0);
    repeat (6) cycle();

    // Fixed-period mode.
    fixed_mode = 1'b1; fixed_period = CW'(12);
    run_to_fe(30, n);
    check("t5_len", 32'(plen5), 12);
    fe_cnt = 0;
    repeat (36) cycle();
    check("t5_count", 32'(fe_cnt), 3);
    fixed_period = '0;
    run_to_fe(20, n);
    check("t5_min5", 32'(plen5), 4);
    repeat (12) cycle();

    // Enable drop mid-period, then asynchronous reset mid-period.
    fixed_mode = 1'b0;
    run_to_fe(20, n);
    repeat (2) cycle();
    en = 1'b0;
    run_to_fe(10, n);
    check("t6_idle", 32'(busy5), 0);
    repeat (10) cycle();
    en = 1'b1;
    repeat (4) cycle();
    #2 rstn = 1'b0;
    #1;
    m5 = idle_model();
    m8 = idle_model();
    check_dut("rst5", expect_out(m5), fe5, mem5, done5, idx5, busy5, plen5);
    check_dut("rst8", expect_out(m8), fe8, mem8, done8, idx8, busy8, plen8);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    run_to_fe(20, n);
    check("t6_latency", 32'(n), 5);

    // Randomised traffic: stalls, enable drops, mode and delay changes at any time.
    for (int i = 0; i < 400; i++) begin
      en           = ($urandom_range(0, 19) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      stage_dly    = NS*DW'($urandom);
      fixed_mode   = ($urandom_range(0, 2) == 0);
      fixed_period = CW'($urandom_range(0, 24));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
